// File: rtl/tx_burst_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tx_burst_scheduler                                               |
// | Brief   : Loads steered pwm phase offsets, then sequences burst and listen. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tx_burst_scheduler #(
  parameter int NUM_CH                 = 4,
  parameter int PERIOD_IN_CLOCK_CYCLES = 2500,
  parameter int BURST_PERIODS          = 8,
  parameter int LISTEN_CYCLES          = 2_000_000,
  localparam int W = $clog2(PERIOD_IN_CLOCK_CYCLES)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic [W-1:0]      delay_step_in,
  input  logic              steer_dir_in,
  output logic [NUM_CH*W-1:0] offsets_out,
  output logic              pwm_rst_out,
  output logic              tx_en_out,
  output logic              listen_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam int c_BURST_LEN = BURST_PERIODS * PERIOD_IN_CLOCK_CYCLES;
  localparam int c_CNT_MAX   = (c_BURST_LEN > LISTEN_CYCLES) ? c_BURST_LEN : LISTEN_CYCLES;
  localparam int c_CW        = $clog2(c_CNT_MAX + 1);
  localparam int c_IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [W:0] c_PERIOD_X = (W+1)'(PERIOD_IN_CLOCK_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SYNC   = 3'd2,
    ST_BURST  = 3'd3,
    ST_LISTEN = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t                     r_state;
  logic [NUM_CH-1:0][W-1:0]   r_offsets;
  logic [W-1:0]               r_step;
  logic                       r_dir;
  logic [W-1:0]               r_acc;
  logic [c_IDX_W-1:0]         r_idx;
  logic [c_CW-1:0]            r_cnt;

  logic [W-1:0]       w_step_clamped;
  logic [W:0]         w_sum;
  logic [W-1:0]       w_acc_next;
  logic [c_IDX_W-1:0] w_ch;

  // Accumulator never exceeds 2*PERIOD-2, so one conditional subtract is a full modulo.
  always_comb begin
    w_step_clamped = ({1'b0, delay_step_in} >= c_PERIOD_X) ? W'(PERIOD_IN_CLOCK_CYCLES - 1)
                                                           : delay_step_in;
    w_sum          = {1'b0, r_acc} + {1'b0, r_step};
    w_acc_next     = (w_sum >= c_PERIOD_X) ? W'(w_sum - c_PERIOD_X) : w_sum[W-1:0];
    w_ch           = r_dir ? (c_IDX_W'(NUM_CH - 1) - r_idx) : r_idx;
  end

  assign offsets_out = r_offsets;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_offsets   <= '0;
      r_step      <= '0;
      r_dir       <= 1'b0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      pwm_rst_out <= 1'b1;
      tx_en_out   <= 1'b0;
      listen_out  <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
    end else if (abort_in && r_state != ST_IDLE) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      pwm_rst_out <= 1'b1;
      tx_en_out   <= 1'b0;
      listen_out  <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done_out <= 1'b0;
          if (start_in && !abort_in) begin
            r_step   <= w_step_clamped;
            r_dir    <= steer_dir_in;
            r_acc    <= '0;
            r_idx    <= '0;
            busy_out <= 1'b1;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_offsets[w_ch] <= r_acc;
          r_acc           <= w_acc_next;
          r_idx           <= r_idx + c_IDX_W'(1);
          if (r_idx == c_IDX_W'(NUM_CH - 1)) r_state <= ST_SYNC;
        end
        ST_SYNC: begin
          r_state     <= ST_BURST;
          r_cnt       <= c_CW'(c_BURST_LEN - 1);
          pwm_rst_out <= 1'b0;
          tx_en_out   <= 1'b1;
        end
        ST_BURST: begin
          if (r_cnt == '0) begin
            r_state     <= ST_LISTEN;
            r_cnt       <= c_CW'(LISTEN_CYCLES - 1);
            pwm_rst_out <= 1'b1;
            tx_en_out   <= 1'b0;
            listen_out  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_CW'(1);
          end
        end
        ST_LISTEN: begin
          if (r_cnt == '0) begin
            r_state    <= ST_DONE;
            listen_out <= 1'b0;
            done_out   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_CW'(1);
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          done_out <= 1'b0;
          busy_out <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          pwm_rst_out <= 1'b1;
          tx_en_out   <= 1'b0;
          listen_out  <= 1'b0;
          busy_out    <= 1'b0;
          done_out    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
